// File: rtl/riscv_aes_pkg.sv
// -----------------------------------------------------------------------------
// riscv_aes_pkg
// Shared definitions for the AES result write-back path.
//   wb_state_e        : write-back FSM states (IDLE, REQ, WAIT_RSP, DONE)
//   AES_WB_NUM_WORDS  : default number of result words written per operation
//   byte_swap()       : reverses the byte order of the low nbytes of a word
// -----------------------------------------------------------------------------
package riscv_aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } wb_state_e;

   localparam int AES_WB_NUM_WORDS = 4;

   // Works on up to 64-bit words; the caller narrows the result back down.
   function automatic logic [63:0] byte_swap(input logic [63:0] w, input int nbytes);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < nbytes) r[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/riscv_aes_writeback.sv
// -----------------------------------------------------------------------------
// riscv_aes_writeback
// Writes a block of AES result words to memory over a req/gnt/rvalid data bus,
// one word per bus transaction, at consecutive word addresses from a base.
//
// Handshake: data_req_o is held with stable address/data until data_gnt_i is
// seen high on a rising edge; the write response is the first data_rvalid_i
// seen while waiting for it. Only one transaction is outstanding at a time and
// data_rvalid_i is ignored in every other state. start_i is only accepted in
// IDLE; requests arriving while busy are dropped.
//
// Parameters : DATA_WIDTH (word / bus width), NUM_WORDS (1..4 words per block)
// Ports      : clk, rst_n (async, active-low)
//              start_i, res_a_i..res_d_i, wb_addr_i   - operation request
//              data_req_o, data_gnt_i, data_rvalid_i,
//              data_addr_o, data_we_o, data_be_o, data_wdata_o - data bus
//              busy_o, done_o                         - status
//              dbg_state_o                            - current FSM state
// Build option: AES_WB_BYTESWAP_EN byte-reverses each word on data_wdata_o.
// -----------------------------------------------------------------------------
module riscv_aes_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = riscv_aes_pkg::AES_WB_NUM_WORDS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] res_a_i,
   input  logic [DATA_WIDTH-1:0] res_b_i,
   input  logic [DATA_WIDTH-1:0] res_c_i,
   input  logic [DATA_WIDTH-1:0] res_d_i,
   input  logic [31:0]           wb_addr_i,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   output logic [31:0]           data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [DATA_WIDTH-1:0] data_wdata_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            dbg_state_o
);
   import riscv_aes_pkg::*;

   localparam logic [1:0] LAST_CNT = 2'(NUM_WORDS - 1);

   wb_state_e             state;
   logic [1:0]            cnt;
   logic [1:0]            cnt_nx;
   logic [31:0]           base_q;
   logic [DATA_WIDTH-1:0] snap [4];

   assign cnt_nx      = cnt + 2'd1;
   assign dbg_state_o = state;

   // Bus data formatting; the snapshot itself always holds unmodified words.
   function automatic logic [DATA_WIDTH-1:0] fmt_word(input logic [DATA_WIDTH-1:0] w);
`ifdef AES_WB_BYTESWAP_EN
      return DATA_WIDTH'(byte_swap(64'(w), DATA_WIDTH / 8));
`else
      return w;
`endif
   endfunction

   // All bus outputs are registered; address and data are zero whenever no
   // request is being presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         base_q       <= '0;
         for (int i = 0; i < 4; i++) snap[i] <= '0;
         data_req_o   <= 1'b0;
         data_we_o    <= 1'b0;
         data_be_o    <= 4'h0;
         data_addr_o  <= '0;
         data_wdata_o <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  snap[0]      <= res_a_i;
                  snap[1]      <= res_b_i;
                  snap[2]      <= res_c_i;
                  snap[3]      <= res_d_i;
                  base_q       <= wb_addr_i & 32'hFFFF_FFFC;
                  cnt          <= '0;
                  data_req_o   <= 1'b1;
                  data_we_o    <= 1'b1;
                  data_be_o    <= 4'hF;
                  data_addr_o  <= wb_addr_i & 32'hFFFF_FFFC;
                  data_wdata_o <= fmt_word(res_a_i);
                  busy_o       <= 1'b1;
                  state        <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (data_gnt_i) begin
                  data_req_o   <= 1'b0;
                  data_we_o    <= 1'b0;
                  data_be_o    <= 4'h0;
                  data_addr_o  <= '0;
                  data_wdata_o <= '0;
                  state        <= ST_WAIT_RSP;
               end
            end
            ST_WAIT_RSP: begin
               if (data_rvalid_i) begin
                  if (cnt == LAST_CNT) begin
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     cnt          <= cnt_nx;
                     data_req_o   <= 1'b1;
                     data_we_o    <= 1'b1;
                     data_be_o    <= 4'hF;
                     // Wraps modulo 2^32 past the top of the address space.
                     data_addr_o  <= base_q + {28'd0, cnt_nx, 2'b00};
                     data_wdata_o <= fmt_word(snap[cnt_nx]);
                     state        <= ST_REQ;
                  end
               end
            end
            ST_DONE: begin
               done_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_aes_writeback.sv
// -----------------------------------------------------------------------------
// tb_riscv_aes_writeback
// Bench for riscv_aes_writeback: a bus responder with per-word grant/response
// delays doubles as the write monitor, checking every presented write against
// an expected queue built from the operation's words and base address.
// -----------------------------------------------------------------------------
module tb_riscv_aes_writeback;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [31:0] res_a_i, res_b_i, res_c_i, res_d_i;
   logic [31:0] wb_addr_i;
   logic        data_req_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        busy_o;
   logic        done_o;
   logic [1:0]  dbg_state_o;

   riscv_aes_writeback dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .res_a_i       (res_a_i),
      .res_b_i       (res_b_i),
      .res_c_i       (res_c_i),
      .res_d_i       (res_d_i),
      .wb_addr_i     (wb_addr_i),
      .data_req_o    (data_req_o),
      .data_gnt_i    (data_gnt_i),
      .data_rvalid_i (data_rvalid_i),
      .data_addr_o   (data_addr_o),
      .data_we_o     (data_we_o),
      .data_be_o     (data_be_o),
      .data_wdata_o  (data_wdata_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .dbg_state_o   (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [63:0]      exp_q[$];          // {addr, data} of each expected write
   int               n_vec = 0;
   int               n_err = 0;
   logic [3:0][3:0]  gnt_tab;           // grant delay per word index
   logic [3:0][3:0]  rsp_tab;           // response delay per word index
   int               w_idx = 0;
   int               grants = 0;
   int               done_cnt = 0;
   bit               stray_en = 0;

   typedef struct {
      logic [3:0][31:0] words;
      logic [31:0]      base;
      logic [3:0][3:0]  gnt_d;
      logic [3:0][3:0]  rsp_d;
      logic [3:0][31:0] exp_addr;
      int               exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef AES_WB_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // ---------------- bus responder + write monitor ----------------
   initial begin
      int  gnt_wait;
      int  rsp_wait;
      bit  req_seen;
      bit  rsp_pending;
      logic [63:0] e;
      gnt_wait = 0; rsp_wait = 0; req_seen = 0; rsp_pending = 0;
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      forever begin
         @(negedge clk);
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
         if (!rst_n) begin
            rsp_pending = 0;
            req_seen    = 0;
         end else begin
            if (done_o) done_cnt++;
            if (data_req_o) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                           data_addr_o, data_wdata_o);
               end else begin
                  e = exp_q[0];
                  check("wr_addr", data_addr_o, e[63:32]);
                  check("wr_data", data_wdata_o, e[31:0]);
                  check("wr_we", data_we_o, 1);
                  check("wr_be", data_be_o, 4'hF);
               end
               if (!req_seen) begin
                  req_seen = 1;
                  gnt_wait = int'(gnt_tab[w_idx & 3]);
               end
               if (gnt_wait == 0) begin
                  data_gnt_i  = 1'b1;
                  req_seen    = 0;
                  rsp_pending = 1;
                  rsp_wait    = int'(rsp_tab[w_idx & 3]);
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  w_idx++;
                  grants++;
               end else begin
                  gnt_wait--;
                  // A response with nothing outstanding must be ignored.
                  if (stray_en && $urandom_range(0, 1) == 1) data_rvalid_i = 1'b1;
               end
            end else begin
               check("idle_bus_zero", {data_addr_o, data_wdata_o}, 64'h0);
               if (rsp_pending) begin
                  if (rsp_wait == 0) begin
                     data_rvalid_i = 1'b1;
                     rsp_pending   = 0;
                  end else begin
                     rsp_wait--;
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_expected(input logic [3:0][31:0] words, input logic [3:0][31:0] addrs);
      for (int i = 0; i < 4; i++) exp_q.push_back({addrs[i], exp_word(words[i])});
   endtask

   task automatic drive_start(input logic [3:0][31:0] words, input logic [31:0] base,
                              input logic [3:0][3:0] gd, input logic [3:0][3:0] rd);
      @(negedge clk);
      gnt_tab   = gd;
      rsp_tab   = rd;
      w_idx     = 0;
      res_a_i   = words[0];
      res_b_i   = words[1];
      res_c_i   = words[2];
      res_d_i   = words[3];
      wb_addr_i = base;
      start_i   = 1'b1;
      @(negedge clk);
      start_i   = 1'b0;
      // Inputs change after capture; the written data must not follow them.
      res_a_i   = $urandom;
      res_b_i   = $urandom;
      res_c_i   = $urandom;
      res_d_i   = $urandom;
      wb_addr_i = $urandom;
   endtask

   task automatic run_op(input string name, input logic [3:0][31:0] words, input logic [31:0] base,
                         input logic [3:0][3:0] gd, input logic [3:0][3:0] rd,
                         input logic [3:0][31:0] ea, input int elat);
      int lat;
      push_expected(words, ea);
      drive_start(words, base, gd, rd);
      lat = 1;
      check({name, "_busy"}, busy_o, 1);
      while (!done_o && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, lat, elat);
      check({name, "_busy_in_done"}, busy_o, 0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, done_o, 0);
      check({name, "_idle_state"}, dbg_state_o, 0);
      check({name, "_all_written"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   vec_t tbl [5];

   initial begin
      logic [3:0][31:0] w;
      logic [3:0][31:0] ea;
      logic [3:0][3:0]  gd;
      logic [3:0][3:0]  rd;
      logic [31:0]      b;
      int               lat;
      int               elat;
      int               d0;

      rst_n = 1'b0; start_i = 1'b0;
      res_a_i = '0; res_b_i = '0; res_c_i = '0; res_d_i = '0; wb_addr_i = '0;
      gnt_tab = '0; rsp_tab = '0;

      tbl[0] = '{words: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                 base: 32'h00001000, gnt_d: '0, rsp_d: '0,
                 exp_addr: {32'h0000100C, 32'h00001008, 32'h00001004, 32'h00001000},
                 exp_lat: 9};
      tbl[1] = '{words: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                 base: 32'h00001000, gnt_d: {4'd0, 4'd3, 4'd0, 4'd0}, rsp_d: '0,
                 exp_addr: {32'h0000100C, 32'h00001008, 32'h00001004, 32'h00001000},
                 exp_lat: 12};
      tbl[2] = '{words: {32'h01020304, 32'h99887766, 32'h55443322, 32'hAABBCCDD},
                 base: 32'hFFFFFFFA, gnt_d: '0, rsp_d: '0,
                 exp_addr: {32'h00000004, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFF8},
                 exp_lat: 9};
      tbl[3] = '{words: {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233},
                 base: 32'h00000013, gnt_d: '0, rsp_d: {4'd1, 4'd1, 4'd1, 4'd1},
                 exp_addr: {32'h0000001C, 32'h00000018, 32'h00000014, 32'h00000010},
                 exp_lat: 13};
      tbl[4] = '{words: {32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF},
                 base: 32'h7FFFFFF4, gnt_d: {4'd1, 4'd1, 4'd1, 4'd1}, rsp_d: {4'd2, 4'd2, 4'd2, 4'd2},
                 exp_addr: {32'h80000000, 32'h7FFFFFFC, 32'h7FFFFFF8, 32'h7FFFFFF4},
                 exp_lat: 21};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_req", data_req_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_we_be", {data_we_o, data_be_o}, 0);
      check("rst_addr_data", {data_addr_o, data_wdata_o}, 0);
      check("rst_state", dbg_state_o, 0);
      rst_n = 1'b1;

      // Table-driven operations
      for (int i = 0; i < 5; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].words, tbl[i].base, tbl[i].gnt_d,
                tbl[i].rsp_d, tbl[i].exp_addr, tbl[i].exp_lat);
      end

      // start_i while busy: dropped, exactly one completion
      w  = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
      ea = {32'h0000300C, 32'h00003008, 32'h00003004, 32'h00003000};
      rd = {4'd2, 4'd2, 4'd2, 4'd2};
      push_expected(w, ea);
      d0 = done_cnt;
      drive_start(w, 32'h00003000, '0, rd);
      lat = 1;
      while (!done_o && lat < 200) begin
         if (lat == 1 || lat == 3 || lat == 6 || lat == 11) begin
            start_i   = 1'b1;
            res_a_i   = $urandom; res_b_i = $urandom;
            res_c_i   = $urandom; res_d_i = $urandom;
            wb_addr_i = $urandom;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start_i = 1'b0;
      check("busy_start_latency", lat, 17);
      repeat (20) @(negedge clk);
      check("busy_start_one_done", done_cnt - d0, 1);
      check("busy_start_no_extra_write", exp_q.size(), 0);
      exp_q.delete();

      // Reset while waiting for the response of word 1
      w  = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
      ea = {32'h0000400C, 32'h00004008, 32'h00004004, 32'h00004000};
      push_expected(w, ea);
      grants = 0;
      drive_start(w, 32'h00004000, '0, {4'd0, 4'd0, 4'd6, 4'd0});
      lat = 0;
      while (grants < 2 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("rst_seq_word1_granted", grants, 2);
      @(negedge clk);
      check("rst_seq_in_wait", dbg_state_o, 2);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_req", data_req_o, 0);
      check("rst_mid_busy", busy_o, 0);
      check("rst_mid_done", done_o, 0);
      check("rst_mid_state", dbg_state_o, 0);
      check("rst_mid_bus", {data_addr_o, data_wdata_o}, 0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_no_busy", busy_o, 0);
      run_op("after_rst", tbl[0].words, tbl[0].base, tbl[0].gnt_d, tbl[0].rsp_d,
             tbl[0].exp_addr, tbl[0].exp_lat);

      // Randomized operations against the address/latency model
      stray_en = 1;
      for (int r = 0; r < 20; r++) begin
         b    = $urandom;
         elat = 1 + 2 * 4;
         for (int k = 0; k < 4; k++) begin
            w[k]  = $urandom;
            gd[k] = 4'($urandom_range(0, 3));
            rd[k] = 4'($urandom_range(0, 3));
            ea[k] = (b - (b % 4)) + 32'(4 * k);
            elat  = elat + int'(gd[k]) + int'(rd[k]);
         end
         run_op($sformatf("rand%0d", r), w, b, gd, rd, ea, elat);
      end
      stray_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_aes_writeback.md
RISCV_AES_WRITEBACK -- requirements
Module: riscv_aes_writeback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each result word and of the data bus.
REQ-002 SHALL have parameter NUM_WORDS, default 4: number of result words written per operation.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1 bit: one-cycle request to write back the current result block.
REQ-006 SHALL have ports res_a_i, res_b_i, res_c_i and res_d_i, input, DATA_WIDTH each: result words 0..3.
REQ-007 SHALL have port wb_addr_i, input, 32 bits: destination base byte address.
REQ-008 SHALL have port data_req_o, output, 1 bit: bus request.
REQ-009 SHALL have port data_gnt_i, input, 1 bit: bus grant.
REQ-010 SHALL have port data_rvalid_i, input, 1 bit: write response valid.
REQ-011 SHALL have port data_addr_o, output, 32 bits: bus address.
REQ-012 SHALL have port data_we_o, output, 1 bit: write enable.
REQ-013 SHALL have port data_be_o, output, 4 bits: byte enables.
REQ-014 SHALL have port data_wdata_o, output, DATA_WIDTH: write data.
REQ-015 SHALL have port busy_o, output, 1 bit: operation in progress.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement an FSM with states IDLE, REQ, WAIT_RSP and DONE.
REQ-018 SHALL, on start_i in IDLE, snapshot all four words and {wb_addr_i[31:2],2'b00}, clear the word counter, and enter REQ on the next cycle.
REQ-019 SHALL ignore start_i whenever the FSM is not in IDLE; no queueing.
REQ-020 SHALL drive data_req_o=1, data_we_o=1, data_be_o=4'hF and data_addr_o=base+4*cnt (mod 2^32, wraps) in REQ.
REQ-021 SHALL take data_wdata_o from snapshot word cnt.
REQ-022 SHALL hold the address and data stable in REQ until data_gnt_i, then go to WAIT_RSP with data_req_o=0 on the next cycle.
REQ-023 SHALL allow at most one outstanding transaction; data_rvalid_i outside WAIT_RSP is ignored.
REQ-024 SHALL, on data_rvalid_i in WAIT_RSP: if cnt==NUM_WORDS-1, go to DONE; otherwise increment cnt and go to REQ.
REQ-025 SHALL stay in DONE for exactly one cycle with done_o=1, then return to IDLE.
REQ-026 SHALL drive busy_o=1 in REQ and WAIT_RSP, and 0 otherwise.
REQ-027 SHALL take NUM_WORDS+... cycles as follows: with a zero-wait bus (gnt same cycle, rvalid next cycle), the minimum latency from start_i to done_o is 1+2*NUM_WORDS cycles (9 cycles by default).
REQ-028 SHALL drive data_wdata_o=0 and data_addr_o=0 while data_req_o=0.

Reset
REQ-029 SHALL, with rst_n low, immediately and asynchronously force IDLE, cnt=0, a zeroed snapshot, and all outputs to 0, including mid-transaction; the bus transaction is abandoned with no replay after reset.

Configuration
REQ-030 SHALL, with AES_WB_BYTESWAP_EN defined, byte-reverse each word on data_wdata_o (e.g. 32'h00112233 -> 32'h33221100).
REQ-031 SHALL, without AES_WB_BYTESWAP_EN, pass words unchanged; no other behaviour differs.

Structure
REQ-032 SHALL take the FSM state enum and the NUM_WORDS default from the shared package riscv_aes_pkg.
REQ-033 SHALL be a single module with no sub-module; the byte swap is a package function.

Verification
REQ-034 SHALL cover: words 0x11111111..0x44444444, base 0x1000, zero-wait bus -> writes to 0x1000/4/8/C in order; done_o 9 cycles after start_i.
REQ-035 SHALL cover: data_gnt_i withheld 3 cycles on word 2 -> data_addr_o=0x1008 and data_wdata_o=0x33333333 held stable; single write issued.
REQ-036 SHALL cover: wb_addr_i=0xFFFFFFFA -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-037 SHALL cover: start_i pulsed while busy with new words -> ignored; original words written; exactly one done_o.
REQ-038 SHALL cover: rst_n asserted in WAIT_RSP of word 1 -> data_req_o=0, busy_o=0 immediately; no done_o; a new start_i after reset starts at word 0.
REQ-039 SHALL cover: AES_WB_BYTESWAP_EN defined, word 0x00112233 -> bus data 0x33221100.
